// File: rtl/mem_access_arbiter_if.sv
// Requester-side and array-side signals of the two-port memory access arbiter.
// Latency: n/a (wires only). Backpressure: requesters hold i_req_* until their o_ack_* pulse.
// MEM_ARB_STATS_EN adds the per-requester grant counters.
interface mem_access_arbiter_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              i_req_a;
    logic [ADDR_W-1:0] i_adr_a;
    logic              i_we_a;
    logic [DATA_W-1:0] i_wdata_a;
    logic              o_ack_a;
    logic              i_req_b;
    logic [ADDR_W-1:0] i_adr_b;
    logic              i_we_b;
    logic [DATA_W-1:0] i_wdata_b;
    logic              o_ack_b;
    logic [DATA_W-1:0] o_rdata;
    logic              o_busy;
    logic [ADDR_W-1:0] o_adr;
    logic              o_valid;
    logic              o_we;
    logic [DATA_W-1:0] o_wdata;
    logic [DATA_W-1:0] i_rdata;
`ifdef MEM_ARB_STATS_EN
    logic [7:0]        o_grant_cnt_a;
    logic [7:0]        o_grant_cnt_b;
`endif

    modport master (
        output i_req_a, i_adr_a, i_we_a, i_wdata_a,
        output i_req_b, i_adr_b, i_we_b, i_wdata_b,
        output i_rdata,
`ifdef MEM_ARB_STATS_EN
        input  o_grant_cnt_a, o_grant_cnt_b,
`endif
        input  o_ack_a, o_ack_b, o_rdata, o_busy, o_adr, o_valid, o_we, o_wdata
    );

    modport slave (
        input  i_req_a, i_adr_a, i_we_a, i_wdata_a,
        input  i_req_b, i_adr_b, i_we_b, i_wdata_b,
        input  i_rdata,
`ifdef MEM_ARB_STATS_EN
        output o_grant_cnt_a, o_grant_cnt_b,
`endif
        output o_ack_a, o_ack_b, o_rdata, o_busy, o_adr, o_valid, o_we, o_wdata
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// Round-robin two-requester arbiter sequencing one access at a time into the 8x8 bit array.
// Latency: ack in the cycle after edge sample+ACCESS_CYCLES+1; one transaction per ACCESS_CYCLES+3 cycles.
// Backpressure: losers simply keep i_req_* high; MEM_ARB_STATS_EN adds saturating grant counters.
module mem_access_arbiter #(
    parameter int ADDR_W        = 3,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 1
) (
    input logic                i_clk,
    input logic                i_rst_n,
    mem_access_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t            state;
    logic [3:0]        accCnt;
    logic              latWe;
    logic              latIdB;
    logic              favourB;
    logic              pickB;
    logic              ackA;
    logic              ackB;
    logic              busy;
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    // B only wins a contest when A was granted last.
    always_comb begin
        pickB = bus.i_req_b && (!bus.i_req_a || favourB);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            accCnt  <= '0;
            latWe   <= 1'b0;
            latIdB  <= 1'b0;
            favourB <= 1'b0;
            ackA    <= 1'b0;
            ackB    <= 1'b0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            we      <= 1'b0;
            adr     <= '0;
            wdata   <= '0;
            rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_req_a || bus.i_req_b) begin
                        state  <= SETUP;
                        busy   <= 1'b1;
                        valid  <= 1'b1;
                        we     <= 1'b0;
                        latIdB <= pickB;
                        latWe  <= pickB ? bus.i_we_b    : bus.i_we_a;
                        adr    <= pickB ? bus.i_adr_b   : bus.i_adr_a;
                        wdata  <= pickB ? bus.i_wdata_b : bus.i_wdata_a;
                    end
                end
                SETUP: begin
                    state  <= ACCESS;
                    accCnt <= CNT_LOAD;
                    we     <= latWe;
                end
                ACCESS: begin
                    if (accCnt == 4'd0) begin
                        state <= DONE;
                        valid <= 1'b0;
                        we    <= 1'b0;
                        ackA  <= !latIdB;
                        ackB  <= latIdB;
                        if (!latWe) begin
                            rdata <= bus.i_rdata;
                        end
                    end else begin
                        accCnt <= accCnt - 4'd1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    ackA    <= 1'b0;
                    ackB    <= 1'b0;
                    busy    <= 1'b0;
                    favourB <= !latIdB;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [7:0] grantCntA;
    logic [7:0] grantCntB;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            grantCntA <= '0;
            grantCntB <= '0;
        end else if (state == DONE) begin
            if (!latIdB && grantCntA != 8'hFF) begin
                grantCntA <= grantCntA + 8'd1;
            end
            if (latIdB && grantCntB != 8'hFF) begin
                grantCntB <= grantCntB + 8'd1;
            end
        end
    end

    assign bus.o_grant_cnt_a = grantCntA;
    assign bus.o_grant_cnt_b = grantCntB;
`endif

    assign bus.o_ack_a = ackA;
    assign bus.o_ack_b = ackB;
    assign bus.o_busy  = busy;
    assign bus.o_valid = valid;
    assign bus.o_we    = we;
    assign bus.o_adr   = adr;
    assign bus.o_wdata = wdata;
    assign bus.o_rdata = rdata;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: default build plus an ACCESS_CYCLES=3 instance.
// Grant counter checks are compiled in when MEM_ARB_STATS_EN is defined.
module tb_mem_access_arbiter;
    logic i_clk;
    logic i_rst_n;

    int checks;
    int failures;
    int vldCnt;
    int weCnt;
    bit bothHigh;
    bit gotA;
    bit gotB;
    int edges;

    mem_access_arbiter_if #(.ADDR_W(3), .DATA_W(8)) busD ();
    mem_access_arbiter_if #(.ADDR_W(3), .DATA_W(8)) busP ();

    mem_access_arbiter #(.ADDR_W(3), .DATA_W(8), .ACCESS_CYCLES(1)) dutD (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (busD)
    );

    mem_access_arbiter #(.ADDR_W(3), .DATA_W(8), .ACCESS_CYCLES(3)) dutP (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (busP)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    // Runs edges on the default instance until an ack shows, tallying valid/we cycles.
    task automatic runUntilAck(output int n);
        n = 0;
        gotA = 1'b0;
        gotB = 1'b0;
        while (n < 20 && !gotA && !gotB) begin
            cyc();
            n++;
            vldCnt += int'(busD.o_valid);
            weCnt  += int'(busD.o_we);
            if (busD.o_ack_a && busD.o_ack_b) bothHigh = 1'b1;
            gotA = busD.o_ack_a;
            gotB = busD.o_ack_b;
        end
        if (!gotA && !gotB) check("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic runUntilAckP(output int n);
        n = 0;
        gotA = 1'b0;
        gotB = 1'b0;
        while (n < 20 && !gotA && !gotB) begin
            cyc();
            n++;
            vldCnt += int'(busP.o_valid);
            weCnt  += int'(busP.o_we);
            gotA = busP.o_ack_a;
            gotB = busP.o_ack_b;
        end
        if (!gotA && !gotB) check("p3_ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic doReset();
        #3;
        i_rst_n = 1'b0;
        cyc();
        cyc();
        #2;
        i_rst_n = 1'b1;
        cyc();
    endtask

    task automatic clearInputs();
        busD.i_req_a = 1'b0; busD.i_adr_a = '0; busD.i_we_a = 1'b0; busD.i_wdata_a = '0;
        busD.i_req_b = 1'b0; busD.i_adr_b = '0; busD.i_we_b = 1'b0; busD.i_wdata_b = '0;
        busD.i_rdata = '0;
        busP.i_req_a = 1'b0; busP.i_adr_a = '0; busP.i_we_a = 1'b0; busP.i_wdata_a = '0;
        busP.i_req_b = 1'b0; busP.i_adr_b = '0; busP.i_we_b = 1'b0; busP.i_wdata_b = '0;
        busP.i_rdata = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        failures = 0;
        bothHigh = 1'b0;
        clearInputs();
        i_rst_n = 1'b0;

        // Reset state
        #3;
        check("rst_outputs", {busD.o_ack_a, busD.o_ack_b, busD.o_busy, busD.o_valid, busD.o_we,
                              busD.o_adr, busD.o_wdata, busD.o_rdata}, 32'd0);
        #20;
        i_rst_n = 1'b1;
        cyc();
        cyc();
        check("idle_busy", 32'(busD.o_busy), 32'd0);

        // A write: adr 5, data A5
        busD.i_req_a = 1'b1; busD.i_adr_a = 3'd5; busD.i_we_a = 1'b1; busD.i_wdata_a = 8'hA5;
        cyc();
        check("wr_setup", {busD.o_busy, busD.o_valid, busD.o_we, busD.o_adr, busD.o_wdata},
              {3'b110, 3'd5, 8'hA5});
        cyc();
        check("wr_access", {busD.o_valid, busD.o_we, busD.o_adr, busD.o_wdata}, {2'b11, 3'd5, 8'hA5});
        cyc();
        check("wr_done", {busD.o_ack_a, busD.o_ack_b, busD.o_valid, busD.o_we, busD.o_adr},
              {4'b1000, 3'd5});
        busD.i_req_a = 1'b0;
        cyc();
        check("wr_ack_single", {busD.o_ack_a, busD.o_busy}, 32'd0);

        // B read returning 3C
        busD.i_req_b = 1'b1; busD.i_adr_b = 3'd3; busD.i_we_b = 1'b0; busD.i_rdata = 8'h3C;
        vldCnt = 0; weCnt = 0;
        runUntilAck(edges);
        check("rd_latency", 32'(edges), 32'd3);
        check("rd_ack_b", {gotA, gotB}, 32'b01);
        check("rd_rdata", 32'(busD.o_rdata), 32'h3C);
        check("rd_no_we", 32'(weCnt), 32'd0);
        check("rd_valid_cycles", 32'(vldCnt), 32'd2);
        busD.i_req_b = 1'b0;
        cyc();

        // Write must not disturb o_rdata
        busD.i_req_a = 1'b1; busD.i_adr_a = 3'd1; busD.i_we_a = 1'b1; busD.i_wdata_a = 8'h11;
        busD.i_rdata = 8'hFF;
        runUntilAck(edges);
        check("wr_keeps_rdata", 32'(busD.o_rdata), 32'h3C);
        busD.i_req_a = 1'b0;
        cyc();

        // Fairness with both held high, from reset
        doReset();
        busD.i_req_a = 1'b1; busD.i_adr_a = 3'd7; busD.i_we_a = 1'b1; busD.i_wdata_a = 8'h5A;
        busD.i_req_b = 1'b1; busD.i_adr_b = 3'd2; busD.i_we_b = 1'b0; busD.i_rdata = 8'h81;
        bothHigh = 1'b0;
        for (int i = 0; i < 6; i++) begin
            runUntilAck(edges);
            check($sformatf("rr_order_%0d", i), {gotA, gotB}, (i % 2 == 0) ? 32'b10 : 32'b01);
            check($sformatf("rr_spacing_%0d", i), 32'(edges), (i == 0) ? 32'd3 : 32'd4);
        end
        check("rr_never_both", 32'(bothHigh), 32'd0);
        busD.i_req_a = 1'b0; busD.i_req_b = 1'b0;
        cyc();

        // Reset in ACCESS of an A write after A was granted last
        busD.i_req_a = 1'b1; busD.i_adr_a = 3'd2; busD.i_we_a = 1'b1; busD.i_wdata_a = 8'h77;
        runUntilAck(edges);
        cyc();
        cyc();
        cyc();
        check("abort_in_access", {busD.o_valid, busD.o_we}, 32'b11);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("abort_async_drop", {busD.o_valid, busD.o_we, busD.o_busy}, 32'd0);
        cyc();
        check("abort_no_ack", {busD.o_ack_a, busD.o_ack_b}, 32'd0);
        busD.i_req_b = 1'b1; busD.i_adr_b = 3'd4; busD.i_we_b = 1'b0;
        i_rst_n = 1'b1;
        runUntilAck(edges);
        check("post_rst_a_first", {gotA, gotB}, 32'b10);
        busD.i_req_a = 1'b0; busD.i_req_b = 1'b0;
        cyc();

        // ACCESS_CYCLES=3 read
        busP.i_req_a = 1'b1; busP.i_adr_a = 3'd6; busP.i_we_a = 1'b0; busP.i_rdata = 8'h5A;
        vldCnt = 0; weCnt = 0;
        runUntilAckP(edges);
        check("p3_latency", 32'(edges), 32'd5);
        check("p3_valid_cycles", 32'(vldCnt), 32'd4);
        check("p3_rdata", {gotA, busP.o_rdata}, {1'b1, 8'h5A});
        busP.i_req_a = 1'b0;
        cyc();

        // ACCESS_CYCLES=3 write: o_we for all three ACCESS cycles
        busP.i_req_b = 1'b1; busP.i_adr_b = 3'd0; busP.i_we_b = 1'b1; busP.i_wdata_b = 8'hC3;
        vldCnt = 0; weCnt = 0;
        runUntilAckP(edges);
        check("p3_we_cycles", 32'(weCnt), 32'd3);
        check("p3_wr_ack_b", {gotA, gotB, busP.o_rdata}, {2'b01, 8'h5A});
        busP.i_req_b = 1'b0;
        cyc();

`ifdef MEM_ARB_STATS_EN
        doReset();
        check("stats_rst", {busD.o_grant_cnt_a, busD.o_grant_cnt_b}, 32'd0);
        busD.i_req_a = 1'b1; busD.i_req_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            runUntilAck(edges);
            if (i == 4) begin
                busD.i_req_a = 1'b0; busD.i_req_b = 1'b0;
            end
        end
        cyc();
        check("stats_3_2", {busD.o_grant_cnt_a, busD.o_grant_cnt_b}, {8'd3, 8'd2});
        busD.i_req_a = 1'b1;
        for (int i = 0; i < 300; i++) begin
            runUntilAck(edges);
        end
        busD.i_req_a = 1'b0;
        cyc();
        check("stats_sat", {busD.o_grant_cnt_a, busD.o_grant_cnt_b}, {8'd255, 8'd2});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
